// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - instruction memory with load sessions and a stallable one-cycle fetch port
// Optional bounds checking with sticky fault output: define INST_FETCH_BOUNDS_CHECK_EN.
module inst_fetch_unit #(
  parameter int                ADDR_W = 32,
  parameter int                INST_W = 32,
  parameter logic [ADDR_W-1:0] BASE   = 32'h0000_0000,
  parameter int                DEPTH  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load_start,
  input  logic [ADDR_W-1:0]         load_base,
  input  logic                      load_valid,
  input  logic [INST_W-1:0]         load_data,
  input  logic                      load_last,
  output logic                      load_ready,
  input  logic                      fetch_req,
  input  logic [ADDR_W-1:0]         fetch_addr,
  output logic                      fetch_ready,
  input  logic                      chip_select,
  output logic                      rsp_valid,
  output logic [INST_W-1:0]         rsp_inst,
  input  logic                      rsp_stall,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    words_loaded
`ifdef INST_FETCH_BOUNDS_CHECK_EN
  ,
  output logic                      fault
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] WL_MAX = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state;
  state_t            state_next;
  logic [INST_W-1:0] mem [DEPTH];
  logic [AW-1:0]     ptr;
  logic              load_accept;
  logic              fetch_fire;
  logic [INST_W-1:0] fetch_word;

  // Offset from BASE in words; higher bits beyond the array simply alias.
  function automatic logic [AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return AW'((a - BASE) >> 2);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    load_ready  = 1'b0;
    busy        = 1'b0;
    fetch_ready = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_next = LOAD;
      end
      LOAD: begin
        load_ready = 1'b1;
        busy       = 1'b1;
        if (!load_start && load_valid && load_last) state_next = RUN;
      end
      RUN: begin
        fetch_ready = !load_start && (!rsp_valid || !rsp_stall);
        if (load_start) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // A restart request wins over a word presented in the same cycle.
  assign load_accept = load_valid && load_ready && !load_start;
  assign fetch_fire  = fetch_req && fetch_ready;

`ifdef INST_FETCH_BOUNDS_CHECK_EN
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  logic in_range;
  assign in_range   = (fetch_addr >= BASE) && (((fetch_addr - BASE) >> 2) < DEPTH_A);
  assign fetch_word = (chip_select && in_range) ? mem[word_idx(fetch_addr)] : '0;
`else
  assign fetch_word = chip_select ? mem[word_idx(fetch_addr)] : '0;
`endif

  // Array contents survive reset so a reload can fill in only what is missing.
  always_ff @(posedge clk) begin
    if (!rst && load_accept) mem[ptr] <= load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr          <= '0;
      words_loaded <= '0;
      rsp_valid    <= 1'b0;
      rsp_inst     <= '0;
    end else begin
      if (load_start) begin
        ptr          <= word_idx(load_base);
        words_loaded <= '0;
      end else if (load_accept) begin
        ptr <= ptr + 1'b1;
        if (words_loaded != WL_MAX) words_loaded <= words_loaded + 1'b1;
      end

      if (load_start) begin
        rsp_valid <= 1'b0;
      end else if (fetch_fire) begin
        rsp_valid <= 1'b1;
        rsp_inst  <= fetch_word;
      end else if (!rsp_stall) begin
        rsp_valid <= 1'b0;
      end
    end
  end

`ifdef INST_FETCH_BOUNDS_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)                          fault <= 1'b0;
    else if (fetch_fire && !in_range) fault <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - directed self-checking bench for inst_fetch_unit (BASE 0x1000, DEPTH 4)
module tb_inst_fetch_unit;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [31:0] load_base;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready;
  logic        chip_select;
  logic        rsp_valid;
  logic [31:0] rsp_inst;
  logic        rsp_stall;
  logic        busy;
  logic [2:0]  words_loaded;
`ifdef INST_FETCH_BOUNDS_CHECK_EN
  logic        fault;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .ADDR_W(32), .INST_W(32), .BASE(BASE), .DEPTH(4)
  ) u_dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_last(load_last), .load_ready(load_ready),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .chip_select(chip_select), .rsp_valid(rsp_valid), .rsp_inst(rsp_inst),
    .rsp_stall(rsp_stall), .busy(busy), .words_loaded(words_loaded)
`ifdef INST_FETCH_BOUNDS_CHECK_EN
    , .fault(fault)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_word(input logic [31:0] d, input logic last);
    load_valid = 1'b1; load_data = d; load_last = last;
    tick();
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic fetch_one(input logic [31:0] a);
    fetch_req = 1'b1; fetch_addr = a;
    tick();
    fetch_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_start = 0; load_base = 0; load_valid = 0; load_data = 0;
    load_last = 0; fetch_req = 1; fetch_addr = BASE; chip_select = 1; rsp_stall = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
    n_checks++; if (rsp_inst !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_inst got %h exp 0", rsp_inst); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy); end
    n_checks++; if (words_loaded !== 3'd0) begin n_fail++; $display("FAIL reset_words got %0d exp 0", words_loaded); end
    n_checks++; if (load_ready !== 1'b0) begin n_fail++; $display("FAIL idle_load_ready got %b exp 0", load_ready); end
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL idle_fetch_ready got %b exp 0", fetch_ready); end
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL idle_no_rsp got %b exp 0", rsp_valid); end
    fetch_req = 0;
`ifdef INST_FETCH_BOUNDS_CHECK_EN
    n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", fault); end
`endif
  endtask

  task automatic test_load();
    load_start = 1; load_base = BASE;
    tick();
    load_start = 0;
    n_checks++; if (busy !== 1'b1 || load_ready !== 1'b1) begin n_fail++; $display("FAIL load_busy got %b/%b exp 1/1", busy, load_ready); end
    load_word(32'h11, 0);
    load_word(32'h22, 0);
    n_checks++; if (words_loaded !== 3'd2) begin n_fail++; $display("FAIL load_words_mid got %0d exp 2", words_loaded); end
    load_word(32'h33, 1);
    n_checks++; if (words_loaded !== 3'd3) begin n_fail++; $display("FAIL load_words got %0d exp 3", words_loaded); end
    n_checks++; if (busy !== 1'b0 || load_ready !== 1'b0) begin n_fail++; $display("FAIL load_done_busy got %b/%b exp 0/0", busy, load_ready); end
    fetch_req = 1; fetch_addr = BASE; #1;
    n_checks++; if (fetch_ready !== 1'b1) begin n_fail++; $display("FAIL run_fetch_ready got %b exp 1", fetch_ready); end
    fetch_req = 0;
  endtask

  task automatic test_back_to_back();
    fetch_req = 1; fetch_addr = BASE + 4;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h22) begin n_fail++; $display("FAIL b2b_first got %b/%h exp 1/22", rsp_valid, rsp_inst); end
    fetch_addr = BASE + 8;
    tick();
    n_checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h33) begin n_fail++; $display("FAIL b2b_second got %b/%h exp 1/33", rsp_valid, rsp_inst); end
    fetch_addr = BASE + 6;
    tick();
    n_checks++; if (rsp_inst !== 32'h22) begin n_fail++; $display("FAIL byte_offset_ignored got %h exp 22", rsp_inst); end
    fetch_req = 0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_clear got %b exp 0", rsp_valid); end
  endtask

  task automatic test_stall();
    fetch_one(BASE);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h11) begin n_fail++; $display("FAIL stall_first got %b/%h exp 1/11", rsp_valid, rsp_inst); end
    rsp_stall = 1; fetch_req = 1; fetch_addr = BASE + 8;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL stall_fetch_ready cyc %0d got %b exp 0", i, fetch_ready); end
      tick();
      n_checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h11) begin n_fail++; $display("FAIL stall_hold cyc %0d got %b/%h exp 1/11", i, rsp_valid, rsp_inst); end
    end
    rsp_stall = 0; fetch_req = 0;
    tick();
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release got %b exp 0", rsp_valid); end
  endtask

  task automatic test_chip_select();
    chip_select = 0;
    fetch_one(BASE);
    n_checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0) begin n_fail++; $display("FAIL cs_zero got %b/%h exp 1/0", rsp_valid, rsp_inst); end
    chip_select = 1;
    tick();
  endtask

  task automatic test_load_clears_rsp();
    fetch_req = 1; fetch_addr = BASE + 4;
    tick();
    fetch_req = 0; rsp_stall = 1; load_start = 1; load_base = BASE; #1;
    n_checks++; if (fetch_ready !== 1'b0) begin n_fail++; $display("FAIL start_blocks_fetch got %b exp 0", fetch_ready); end
    tick();
    load_start = 0; rsp_stall = 0;
    n_checks++; if (rsp_valid !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL load_clears_rsp got %b/%b exp 0/1", rsp_valid, busy); end
    load_word(32'hB0, 0);
    load_start = 1; load_base = BASE + 8;
    tick();
    load_start = 0;
    n_checks++; if (words_loaded !== 3'd0 || busy !== 1'b1) begin n_fail++; $display("FAIL restart got %0d/%b exp 0/1", words_loaded, busy); end
  endtask

  task automatic test_reset_mid_load();
    load_start = 1; load_base = BASE;
    tick();
    load_start = 0;
    load_word(32'hA0, 0);
    load_word(32'hA1, 0);
    rst = 1;
    tick();
    rst = 0;
    n_checks++; if (busy !== 1'b0 || load_ready !== 1'b0 || words_loaded !== 3'd0) begin n_fail++; $display("FAIL rst_mid_load got %b/%b/%0d exp 0/0/0", busy, load_ready, words_loaded); end
    load_start = 1; load_base = BASE + 8;
    tick();
    load_start = 0;
    load_word(32'hA2, 0);
    load_word(32'hA3, 1);
    n_checks++; if (words_loaded !== 3'd2 || busy !== 1'b0) begin n_fail++; $display("FAIL reload_done got %0d/%b exp 2/0", words_loaded, busy); end
    fetch_one(BASE);
    n_checks++; if (rsp_inst !== 32'hA0) begin n_fail++; $display("FAIL kept_word0 got %h exp a0", rsp_inst); end
    fetch_one(BASE + 4);
    n_checks++; if (rsp_inst !== 32'hA1) begin n_fail++; $display("FAIL kept_word1 got %h exp a1", rsp_inst); end
    fetch_one(BASE + 12);
    n_checks++; if (rsp_inst !== 32'hA3) begin n_fail++; $display("FAIL reload_word3 got %h exp a3", rsp_inst); end
  endtask

  task automatic test_wrap();
    load_start = 1; load_base = BASE + 12;
    tick();
    load_start = 0;
    load_word(32'h51, 0);
    load_word(32'h52, 0);
    load_word(32'h53, 0);
    load_word(32'h54, 0);
    n_checks++; if (words_loaded !== 3'd4) begin n_fail++; $display("FAIL wrap_words4 got %0d exp 4", words_loaded); end
    load_word(32'h55, 1);
    n_checks++; if (words_loaded !== 3'd4 || busy !== 1'b0) begin n_fail++; $display("FAIL wrap_saturate got %0d/%b exp 4/0", words_loaded, busy); end
    fetch_one(BASE);
    n_checks++; if (rsp_inst !== 32'h52) begin n_fail++; $display("FAIL wrap_idx0 got %h exp 52", rsp_inst); end
    fetch_one(BASE + 12);
    n_checks++; if (rsp_inst !== 32'h55) begin n_fail++; $display("FAIL wrap_idx3 got %h exp 55", rsp_inst); end
    fetch_one(BASE + 16);
`ifdef INST_FETCH_BOUNDS_CHECK_EN
    n_checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h0) begin n_fail++; $display("FAIL oob_rsp got %b/%h exp 1/0", rsp_valid, rsp_inst); end
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL oob_fault got %b exp 1", fault); end
    tick();
    n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL fault_sticky got %b exp 1", fault); end
`else
    n_checks++; if (rsp_valid !== 1'b1 || rsp_inst !== 32'h52) begin n_fail++; $display("FAIL oob_alias got %b/%h exp 1/52", rsp_valid, rsp_inst); end
`endif
  endtask

  initial begin
    test_reset();
    test_load();
    test_back_to_back();
    test_stall();
    test_chip_select();
    test_load_clears_rsp();
    test_reset_mid_load();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
